// File: rtl/urv_mem_arbiter.sv
// Shares one synchronous SRAM between the uRV fetch and data ports; data wins the slot
// unless it has starved fetch for g_fetch_starve_limit consecutive grants.
module urv_mem_arbiter #(
  parameter int g_addr_width         = 14,
  parameter int g_fetch_starve_limit = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [31:0]             im_addr_i,
  output logic [31:0]             im_data_o,
  output logic                    im_valid_o,
  input  logic [31:0]             dm_addr_i,
  input  logic [31:0]             dm_data_s_i,
  input  logic [3:0]              dm_data_select_i,
  input  logic                    dm_load_i,
  input  logic                    dm_store_i,
  output logic                    dm_ready_o,
  output logic [31:0]             dm_data_l_o,
  output logic                    dm_load_done_o,
  output logic                    dm_store_done_o,
  output logic                    mem_en_o,
  output logic                    mem_wr_o,
  output logic [3:0]              mem_bwe_o,
  output logic [g_addr_width-1:0] mem_addr_o,
  output logic [31:0]             mem_data_o,
  input  logic [31:0]             mem_data_i
);

  localparam int CW = (g_fetch_starve_limit > 0) ? $clog2(g_fetch_starve_limit + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(g_fetch_starve_limit);

  typedef enum logic {ST_WAKE, ST_RUN} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_LOAD, TAG_STORE} tag_t;

  state_t state_q, state_d;
  tag_t   tag_q, tag_d;

  logic                    pend_valid;
  logic                    pend_is_store;
  logic [g_addr_width-1:0] pend_waddr;
  logic [31:0]             pend_data;
  logic [3:0]              pend_sel;
  logic [CW-1:0]           starve_cnt;

  logic data_gnt;
  logic fetch_gnt;
  logic starved;
  logic accept;
  logic unused_addr_bits;

  // Only the word-address field is used; byte offset and upper bits alias.
  assign unused_addr_bits = ^{im_addr_i, dm_addr_i};

  assign starved    = (g_fetch_starve_limit != 0) && (starve_cnt == LIMIT);
  assign dm_ready_o = !pend_valid || data_gnt;
  assign accept     = dm_ready_o && (dm_load_i || dm_store_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAKE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = TAG_NONE;
    data_gnt   = 1'b0;
    fetch_gnt  = 1'b0;
    mem_en_o   = 1'b0;
    mem_wr_o   = 1'b0;
    mem_bwe_o  = 4'b0000;
    mem_addr_o = '0;
    mem_data_o = 32'h0;
    case (state_q)
      ST_WAKE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_en_o = 1'b1;
        if (pend_valid && !starved) begin
          data_gnt   = 1'b1;
          mem_addr_o = pend_waddr;
          if (pend_is_store) begin
            tag_d      = TAG_STORE;
            mem_wr_o   = 1'b1;
            mem_bwe_o  = pend_sel;
            mem_data_o = pend_data;
          end else begin
            tag_d = TAG_LOAD;
          end
        end else begin
          // Ungranted fetches are simply dropped; the fetch unit re-presents.
          fetch_gnt  = 1'b1;
          tag_d      = TAG_FETCH;
          mem_addr_o = im_addr_i[g_addr_width+1:2];
        end
      end
      default: state_d = ST_WAKE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_valid    <= 1'b0;
      pend_is_store <= 1'b0;
      pend_waddr    <= '0;
      pend_data     <= 32'h0;
      pend_sel      <= 4'b0000;
      starve_cnt    <= '0;
      tag_q         <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
      if (accept) begin
        pend_valid    <= 1'b1;
        pend_is_store <= dm_store_i;
        pend_waddr    <= dm_addr_i[g_addr_width+1:2];
        pend_data     <= dm_data_s_i;
        pend_sel      <= dm_data_select_i;
      end else if (data_gnt) begin
        pend_valid <= 1'b0;
      end
      if (fetch_gnt) begin
        starve_cnt <= '0;
      end else if (data_gnt && (g_fetch_starve_limit != 0) && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign im_valid_o      = (tag_q == TAG_FETCH);
  assign im_data_o       = im_valid_o ? mem_data_i : 32'h0;
  assign dm_load_done_o  = (tag_q == TAG_LOAD);
  assign dm_data_l_o     = dm_load_done_o ? mem_data_i : 32'h0;
  assign dm_store_done_o = (tag_q == TAG_STORE);

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Bench for urv_mem_arbiter: SRAM model plus a slot-level reference model of the arbitration rules.
module tb_urv_mem_arbiter;
  localparam int AW    = 14;
  localparam int LIM   = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [31:0]   im_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0]    dm_sel = '0;
  logic          dm_ld = 1'b0, dm_st = 1'b0;

  logic [31:0]   im_data, dm_data_l, mem_wdata, mem_rdata;
  logic          im_valid, dm_ready, ld_done, st_done, mem_en, mem_wr;
  logic [3:0]    mem_bwe;
  logic [AW-1:0] mem_addr;

  logic [31:0]   z_im_data, z_dm_data_l, z_mem_wdata;
  logic          z_im_valid, z_dm_ready, z_ld_done, z_st_done, z_mem_en, z_mem_wr;
  logic [3:0]    z_mem_bwe;
  logic [AW-1:0] z_mem_addr;

  urv_mem_arbiter #(.g_addr_width(AW), .g_fetch_starve_limit(LIM)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(im_addr), .im_data_o(im_data), .im_valid_o(im_valid),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel), .dm_load_i(dm_ld),
    .dm_store_i(dm_st), .dm_ready_o(dm_ready), .dm_data_l_o(dm_data_l), .dm_load_done_o(ld_done),
    .dm_store_done_o(st_done), .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_bwe_o(mem_bwe),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata));

  // Unlimited-starvation instance: only its fetch behaviour is observed.
  urv_mem_arbiter #(.g_addr_width(AW), .g_fetch_starve_limit(0)) dut_nolim (
    .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(im_addr), .im_data_o(z_im_data), .im_valid_o(z_im_valid),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel), .dm_load_i(dm_ld),
    .dm_store_i(dm_st), .dm_ready_o(z_dm_ready), .dm_data_l_o(z_dm_data_l), .dm_load_done_o(z_ld_done),
    .dm_store_done_o(z_st_done), .mem_en_o(z_mem_en), .mem_wr_o(z_mem_wr), .mem_bwe_o(z_mem_bwe),
    .mem_addr_o(z_mem_addr), .mem_data_o(z_mem_wdata), .mem_data_i(32'h0));

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Synchronous SRAM, read-before-write, preloaded with a known pattern.
  logic [31:0] sram [DEPTH];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] = pat(i);
      loaded = 1'b1;
    end
    if (mem_en) begin
      mem_rdata <= sram[mem_addr];
      if (mem_wr)
        for (int b = 0; b < 4; b++)
          if (mem_bwe[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference state: memory image, one pending request, owner of last slot.
  logic [31:0] ref_mem [DEPTH];
  bit          m_pend, m_is_st, m_run;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [3:0]  m_sel;
  int          m_consec, m_last;   // m_last: 0 none, 1 fetch, 2 load, 3 store

  logic        s_rst_n = 1'b0, s_ld = 1'b0, s_st = 1'b0;
  logic [31:0] s_im_addr = '0, s_addr = '0, s_data = '0;
  logic [3:0]  s_sel = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(bit check_nolim);
    bit dgnt, fgnt, rdy;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_bwe;
    logic        e_wr;
    int w;
    @(posedge clk); #1;
    rst_n = s_rst_n; im_addr = s_im_addr; dm_addr = s_addr; dm_wdata = s_data;
    dm_sel = s_sel; dm_ld = s_ld; dm_st = s_st;
    @(negedge clk);
    if (!s_rst_n) begin
      chk("rst_im_valid", 32'(im_valid), 0);  chk("rst_im_data", im_data, 0);
      chk("rst_dm_data_l", dm_data_l, 0);     chk("rst_ld_done", 32'(ld_done), 0);
      chk("rst_st_done", 32'(st_done), 0);    chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_wr", 32'(mem_wr), 0);      chk("rst_mem_bwe", 32'(mem_bwe), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);  chk("rst_mem_data", mem_wdata, 0);
      chk("rst_dm_ready", 32'(dm_ready), 1);
      m_pend = 0; m_run = 0; m_consec = 0; m_last = 0;
      return;
    end
    chk("im_valid", 32'(im_valid), 32'(m_last == 1));
    chk("im_data", im_data, (m_last == 1) ? m_rdata : 32'h0);
    chk("ld_done", 32'(ld_done), 32'(m_last == 2));
    chk("dm_data_l", dm_data_l, (m_last == 2) ? m_rdata : 32'h0);
    chk("st_done", 32'(st_done), 32'(m_last == 3));

    dgnt = m_run && m_pend && (LIM == 0 || m_consec < LIM);
    fgnt = m_run && !dgnt;
    rdy  = !m_pend || dgnt;
    e_addr = 0; e_wr = 0; e_bwe = 0; e_data = 0;
    if (dgnt) begin
      e_addr = 32'(word_of(m_addr));
      e_wr   = m_is_st;
      e_bwe  = m_is_st ? m_sel : 4'b0000;
      e_data = m_is_st ? m_data : 32'h0;
    end else if (fgnt) begin
      e_addr = 32'(word_of(s_im_addr));
    end
    chk("dm_ready", 32'(dm_ready), 32'(rdy));
    chk("mem_en", 32'(mem_en), 32'(m_run));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    chk("mem_bwe", 32'(mem_bwe), 32'(e_bwe));
    chk("mem_addr", 32'(mem_addr), e_addr);
    chk("mem_data", mem_wdata, e_data);
    if (check_nolim) chk("nolim_im_valid", 32'(z_im_valid), 0);

    if (dgnt) begin
      w = word_of(m_addr);
      if (m_is_st) begin
        for (int b = 0; b < 4; b++)
          if (m_sel[b]) ref_mem[w][8*b +: 8] = m_data[8*b +: 8];
        m_last = 3;
      end else begin
        m_rdata = ref_mem[w];
        m_last  = 2;
      end
      if (m_consec < LIM) m_consec++;
      m_pend = 0;
    end else if (fgnt) begin
      m_rdata  = ref_mem[word_of(s_im_addr)];
      m_last   = 1;
      m_consec = 0;
    end else begin
      m_last = 0;
    end
    if (rdy && (s_ld || s_st)) begin
      m_pend = 1; m_is_st = s_st; m_addr = s_addr; m_data = s_data; m_sel = s_sel;
    end
    m_run = 1;
  endtask

  task automatic op(bit ld, bit st, logic [31:0] a, logic [31:0] d, logic [3:0] sel, bit cz);
    s_ld = ld; s_st = st; s_addr = a; s_data = d; s_sel = sel;
    cycle(cz);
    s_im_addr += 4;
    s_ld = 0; s_st = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) op(0, 0, 32'h0, 32'h0, 4'h0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    m_pend = 0; m_run = 0; m_consec = 0; m_last = 0; m_is_st = 0;
    m_addr = 0; m_data = 0; m_sel = 0; m_rdata = 0;

    s_rst_n = 0;
    cycle(0);
    cycle(0);
    s_rst_n = 1;
    s_im_addr = 32'h0;
    idle(5);                                            // wake cycle, then fetches 0x4.. stream

    op(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0);            // load 0x100
    idle(3);
    op(0, 1, 32'h0000_0203, 32'h0000_00AB, 4'b1000, 0); // byte store to word 0x80
    idle(2);
    op(1, 0, 32'h0000_0200, 32'h0, 4'h0, 0);
    idle(2);

    for (int i = 0; i < 24; i++)                        // continuous data traffic
      op(i[0], !i[0], 32'h1000 + 32'(i) * 4, $urandom, 4'($urandom), i >= 3);
    idle(2);

    op(1, 1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 0);    // both strobes: store wins
    idle(1);
    op(1, 0, 32'h0000_0300, 32'h0, 4'h0, 0);
    op(1, 0, 32'hFFFF_0010, 32'h0, 4'h0, 0);            // aliases to word 0x0004
    idle(2);
    op(0, 1, 32'h0000_0304, 32'h1234_5678, 4'h0, 0);    // empty select still completes
    idle(2);

    op(1, 0, 32'h0000_0400, 32'h0, 4'h0, 0);            // reset between accept and completion
    s_rst_n = 0;
    cycle(0);
    s_rst_n = 1;
    idle(4);

    for (int i = 0; i < 400; i++) begin
      s_im_addr = $urandom;
      op($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom, $urandom, 4'($urandom), 0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
